bin_stream_tx: RTL and testbench

BIN_STREAM_TX -- requirements
Module: bin_stream_tx

---
 rtl/bin_stream_tx.sv | 200 ++++++++++++++++++++
 tb/tb_bin_stream_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_stream_tx.sv
`timescale 1ns/1ps
// bin_stream_tx: turns a byte stream of binary pixels (bit 0 first) into vsync/href/clken/bit
// frame timing. Define BIN_TX_TEST_PATTERN_EN to add a checkerboard pattern selected by pattern_en.
module bin_stream_tx #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480,
  parameter logic [9:0] H_BLANK   = 10'd160,
  parameter int         VS_LINES  = 2,
  parameter int         VBP_LINES = 20,
  parameter int         VFP_LINES = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       tx_vsync,
  output logic       tx_href,
  output logic       tx_clken,
  output logic       tx_img_Bit,
  output logic       frame_done,
  output logic       underflow,
  input  logic       pattern_en
);

  localparam logic [10:0] BLK_LAST = {1'b0, IMG_HDISP} + {1'b0, H_BLANK} - 11'd1;
  localparam logic [10:0] ACT_LAST = {1'b0, IMG_HDISP} - 11'd1;
  localparam logic [10:0] HB_LAST  = {1'b0, H_BLANK} - 11'd1;
  localparam logic [9:0]  VD_LAST  = IMG_VDISP - 10'd1;
  localparam logic [9:0]  VS_LAST  = 10'(VS_LINES - 1);
  localparam logic [9:0]  VBP_LAST = 10'(VBP_LINES - 1);
  localparam logic [9:0]  VFP_LAST = 10'(VFP_LINES - 1);

  typedef enum logic [2:0] {IDLE, VS, VBP, ACT, HBLK, VFP} state_t;

  state_t      state, state_nxt;
  logic [10:0] hcnt, hcnt_nxt;
  logic [9:0]  lcnt, lcnt_nxt, lines_last;
  logic        frame_end;

  logic        pat, pat_nxt;
  logic        load, pop, push, uf_set, flush, pop_nxt, pix, s_ready_nxt;
  logic [7:0]  ld_byte, sr, sr_nxt;
  logic [7:0]  fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  cnt, cnt_nxt;

  always_comb begin
    case (state)
      VS:      lines_last = VS_LAST;
      VBP:     lines_last = VBP_LAST;
      default: lines_last = VFP_LAST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      lcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      lcnt  <= lcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt + 11'd1;
    lcnt_nxt  = lcnt;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        hcnt_nxt = '0;
        lcnt_nxt = '0;
        if (enable) state_nxt = VS;
      end
      VS, VBP, VFP: begin
        if (hcnt == BLK_LAST) begin
          hcnt_nxt = '0;
          lcnt_nxt = lcnt + 10'd1;
          if (lcnt == lines_last) begin
            lcnt_nxt = '0;
            case (state)
              VS:      state_nxt = VBP;
              VBP:     state_nxt = ACT;
              default: begin
                // enable is only honoured here, so a frame is never cut short
                frame_end = 1'b1;
                state_nxt = enable ? VS : IDLE;
              end
            endcase
          end
        end
      end
      ACT: begin
        if (hcnt == ACT_LAST) begin
          hcnt_nxt  = '0;
          state_nxt = HBLK;
        end
      end
      HBLK: begin
        if (hcnt == HB_LAST) begin
          hcnt_nxt = '0;
          if (lcnt == VD_LAST) begin
            lcnt_nxt  = '0;
            state_nxt = VFP;
          end else begin
            lcnt_nxt  = lcnt + 10'd1;
            state_nxt = ACT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BIN_TX_TEST_PATTERN_EN
  logic pat_q;
  always_ff @(posedge clk) begin
    if (rst) pat_q <= 1'b0;
    else     pat_q <= pattern_en;
  end
  assign pat     = pat_q;
  assign pat_nxt = pattern_en;
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
  assign pat     = 1'b0;
  assign pat_nxt = 1'b0;
`endif

  // a load point with an empty FIFO substitutes zeros so line timing never stalls
  assign load    = (state == ACT) && (hcnt[2:0] == 3'd0) && !pat;
  assign pop     = load && (cnt != 2'd0);
  assign uf_set  = load && (cnt == 2'd0);
  assign push    = s_valid && s_ready;
  assign ld_byte = pop ? fifo_mem[rd_ptr] : 8'h00;
  assign sr_nxt  = load ? {1'b0, ld_byte[7:1]} : {1'b0, sr[7:1]};
  assign flush   = (state_nxt == IDLE);
  assign cnt_nxt = flush ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};

  // ready looks one cycle ahead so a full FIFO can still take a byte on a pop cycle
  assign pop_nxt     = (state_nxt == ACT) && (hcnt_nxt[2:0] == 3'd0) && !pat_nxt;
  assign s_ready_nxt = (state_nxt != IDLE) && !pat_nxt && ((cnt_nxt != 2'd2) || pop_nxt);

  always_comb begin
    pix = load ? ld_byte[0] : sr[0];
`ifdef BIN_TX_TEST_PATTERN_EN
    if (pat) pix = hcnt[3] ^ lcnt[3];
`endif
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      sr     <= 8'h00;
    end else begin
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt_nxt;
      if (state == ACT) sr <= sr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready    <= 1'b0;
      tx_vsync   <= 1'b0;
      tx_href    <= 1'b0;
      tx_clken   <= 1'b0;
      tx_img_Bit <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      s_ready    <= s_ready_nxt;
      tx_vsync   <= (state == VS);
      tx_href    <= (state == ACT);
      tx_clken   <= (state == ACT);
      tx_img_Bit <= (state == ACT) && pix;
      frame_done <= frame_end;
      if (state == VS && hcnt == 11'd0 && lcnt == 10'd0) underflow <= 1'b0;
      else if (uf_set)                                    underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bin_stream_tx.sv
`timescale 1ns/1ps
// Bench for bin_stream_tx: a frame-position/queue model checked every cycle, plus literal checks.
module tb_bin_stream_tx;

  localparam int HD = 16, VD = 4, HB = 4, NVS = 1, NVBP = 1, NVFP = 1;
  localparam int L = HD + HB;
  localparam int FRAME = (NVS + NVBP + VD + NVFP) * L;

  logic clk = 1'b0;
  logic rst, enable, s_valid, pattern_en;
  logic [7:0] s_data;
  logic s_ready, tx_vsync, tx_href, tx_clken, tx_img_Bit, frame_done, underflow;

  logic [7:0] byte_tab [256];
  logic [7:0] src_idx;
  assign s_data = byte_tab[src_idx];

  int checks, errors, nprint;

  logic mvalid;
  logic e_ready, e_vs, e_hr, e_bit, e_fd, e_uf;

  always #5 clk = ~clk;

  bin_stream_tx #(
    .IMG_HDISP(10'd16), .IMG_VDISP(10'd4), .H_BLANK(10'd4),
    .VS_LINES(NVS), .VBP_LINES(NVBP), .VFP_LINES(NVFP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .tx_vsync(tx_vsync), .tx_href(tx_href), .tx_clken(tx_clken), .tx_img_Bit(tx_img_Bit),
    .frame_done(frame_done), .underflow(underflow), .pattern_en(pattern_en)
  );

  // Model: p is the position inside the frame (-1 = idle); outputs follow one cycle later.
  initial begin : model
    int p, line, col, a;
    logic [7:0] q[$];
    logic [7:0] cur;
    logic uf, pe_q, pe, r, en, sv, pen, ld;
    logic [7:0] sd;
    for (int i = 0; i < 256; i++) byte_tab[i] = 8'(i * 37) ^ 8'h5A;
    byte_tab[0] = 8'h01;
    byte_tab[1] = 8'hFF;
    src_idx <= 8'd0;
    p = -1; cur = 8'h00; uf = 1'b0; pe_q = 1'b0; mvalid = 1'b0;
    e_ready = 0; e_vs = 0; e_hr = 0; e_bit = 0; e_fd = 0; e_uf = 0;
    forever begin
      @(posedge clk);
      r = rst; en = enable; sv = s_valid; sd = s_data;
`ifdef BIN_TX_TEST_PATTERN_EN
      pen = pattern_en;
`else
      pen = 1'b0;
`endif
      if (r) begin
        p = -1; q.delete(); uf = 1'b0; cur = 8'h00; pe_q = 1'b0; mvalid = 1'b1;
        e_ready = 0; e_vs = 0; e_hr = 0; e_bit = 0; e_fd = 0; e_uf = 0;
      end else begin
        pe = pe_q;
        e_vs = 0; e_hr = 0; e_bit = 0; e_fd = 0;
        if (p >= 0) begin
          line = p / L; col = p % L; a = line - NVS - NVBP;
          if (p == 0) uf = 1'b0;
          e_vs = (line < NVS);
          if (a >= 0 && a < VD && col < HD) begin
            e_hr = 1'b1;
            if (!pe && col % 8 == 0) begin
              if (q.size() > 0) cur = q.pop_front();
              else begin cur = 8'h00; uf = 1'b1; end
            end
            e_bit = pe ? (((col >> 3) & 1) != ((a >> 3) & 1)) : cur[col % 8];
          end
          e_fd = (p == FRAME - 1);
        end
        if (sv && e_ready) begin
          q.push_back(sd);
          src_idx <= src_idx + 8'd1;
        end
        if (p < 0) p = en ? 0 : -1;
        else if (p == FRAME - 1) begin
          p = en ? 0 : -1;
          if (p < 0) q.delete();
        end else p++;
        pe_q = pen;
        e_ready = 1'b0;
        if (p >= 0 && !pe_q) begin
          line = p / L; col = p % L; a = line - NVS - NVBP;
          ld = (a >= 0 && a < VD && col < HD && col % 8 == 0);
          e_ready = (q.size() < 2) || ld;
        end
        e_uf = uf;
      end
    end
  end

  function automatic logic [6:0] outs();
    return {s_ready, tx_vsync, tx_href, tx_clken, tx_img_Bit, frame_done, underflow};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_loop();
    logic [6:0] want;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        want = {e_ready, e_vs, e_hr, e_hr, e_bit, e_fd, e_uf};
        checks++;
        if (outs() !== want) begin
          errors++;
          if (nprint < 20) $display("FAIL cycle_cmp t=%0t got %b want %b (rdy vs href clken bit fd uf)", $time, outs(), want);
          nprint++;
        end
      end
    end
  endtask

  function automatic logic sel_sig(input int s);
    case (s)
      0:       return tx_href;
      1:       return tx_vsync;
      default: return frame_done;
    endcase
  endfunction

  task automatic wait_rise(input int s, input int limit, input string nm);
    logic prev, cur;
    prev = sel_sig(s);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cur = sel_sig(s);
      if (cur === 1'b1 && prev !== 1'b1) return;
      prev = cur;
    end
    checks++; errors++;
    $display("FAIL %s timeout got no edge want edge within %0d cycles", nm, limit);
  endtask

  task automatic grab(output logic [15:0] b);
    b[0] = tx_img_Bit;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      b[i] = tx_img_Bit;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] bits;
    int n, nv, nh;
    checks = 0; errors = 0; nprint = 0;
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; pattern_en = 1'b0;
    fork cmp_loop(); join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'(outs()), 32'd0);

    // continuous frames with an always-valid source
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1; s_valid = 1'b1;
    wait_rise(0, 100, "line0_href");
    grab(bits);
    check("line0_bits", 32'(bits), 32'hFF01);
    check("line0_uf", 32'(underflow), 32'd0);
    wait_rise(2, 300, "fd_first");
    n = 0; nv = 0; nh = 0;
    do begin
      @(negedge clk);
      n++; nv += int'(tx_vsync); nh += int'(tx_href);
    end while (frame_done !== 1'b1 && n < 400);
    check("frame_period", 32'(n), 32'd140);
    check("vsync_cycles", 32'(nv), 32'd20);
    check("href_cycles", 32'(nh), 32'd64);

    // starve the source so line 2 finds the FIFO empty
    wait_rise(0, 100, "uf_line0");
    repeat (16) @(negedge clk);
    s_valid = 1'b0;
    wait_rise(0, 100, "uf_line1");
    wait_rise(0, 100, "uf_line2");
    grab(bits);
    check("line2_bits", 32'(bits), 32'h0000);
    check("line2_uf", 32'(underflow), 32'd1);
    s_valid = 1'b1;
    wait_rise(2, 200, "fd_uf");
    check("uf_at_fd", 32'(underflow), 32'd1);
    @(negedge clk);
    check("vs_after_fd", 32'(tx_vsync), 32'd1);
    check("uf_cleared_vs", 32'(underflow), 32'd0);

    // drop enable mid line 1: frame completes then idles
    wait_rise(0, 100, "en_line0");
    wait_rise(0, 100, "en_line1");
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_rise(2, 200, "fd_enable_drop");
    repeat (3) @(negedge clk);
    check("idle_outs", 32'(outs()), 32'd0);
    repeat (10) @(negedge clk);
    check("idle_outs_later", 32'(outs()), 32'd0);

    // reset during active pixel 5, then a full restart frame
    enable = 1'b1;
    wait_rise(0, 100, "rst_line0");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    wait_rise(1, 10, "vs_restart");
    n = 0;
    while (frame_done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("restart_len", 32'(n), 32'd139);

    // pattern request; ignored unless the pattern build option is present
    pattern_en = 1'b1;
    wait_rise(0, 100, "pat_line0");
    grab(bits);
`ifdef BIN_TX_TEST_PATTERN_EN
    check("pat_bits", 32'(bits), 32'hFF00);
    check("pat_ready", 32'(s_ready), 32'd0);
    check("pat_uf", 32'(underflow), 32'd0);
`endif
    pattern_en = 1'b0;

    enable = 1'b0;
    wait_rise(2, 300, "fd_end");
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
